// File: rtl/pulse_det_ctrl_if.sv
// Pulse-detector control bus: arm/abort handshake, run configuration,
// qualified serial input and the run status outputs.
interface pulse_det_ctrl_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 16
) ();
    logic             start;
    logic             abort;
    logic [3:0]       cfg_pattern;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;
    logic [WIN_W-1:0] cfg_window;
    logic             in;
    logic             in_valid;
    logic             busy;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             done;
    logic             timeout;

    // Controller side: drives requests, config and data, observes status.
    modport master (
        output start, abort, cfg_pattern, cfg_overlap, cfg_target, cfg_window, in, in_valid,
        input  busy, match, match_cnt, done, timeout
    );

    // Detector side.
    modport slave (
        input  start, abort, cfg_pattern, cfg_overlap, cfg_target, cfg_window, in, in_valid,
        output busy, match, match_cnt, done, timeout
    );
endinterface

// File: rtl/pulse_det_ctrl.sv
// Armed serial 4-bit pattern detector. Counts matches up to a target, with an
// optional armed-cycle window, abort, and overlapping/non-overlapping modes.
module pulse_det_ctrl #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 16
) (
    input logic              clk,
    input logic              rst,
    pulse_det_ctrl_if.slave  bus
);

    typedef enum logic [3:0] {
        StIdle    = 4'b0001,
        StArmed   = 4'b0010,
        StDone    = 4'b0100,
        StTimeout = 4'b1000
    } state_e;

    state_e           state_q;

    // Configuration latched when a run is accepted.
    logic [3:0]       pat_q;
    logic             ovl_q;
    logic [CNT_W-1:0] tgt_q;
    logic [WIN_W-1:0] win_len_q;

    logic [3:0]       hist_q;
    logic [2:0]       fill_q;
    logic [WIN_W-1:0] win_q;
    logic [CNT_W-1:0] cnt_q;

    logic             busy_q;
    logic             match_q;
    logic             done_q;
    logic             timeout_q;

    logic [3:0]       hist_nxt;
    logic [2:0]       fill_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIN_W-1:0] win_nxt;
    logic             hit;
    logic             last;
    logic             expire;

    // Next history/fill, match detection, completion and window expiry for this edge.
    always_comb begin
        hist_nxt = hist_q;
        fill_nxt = fill_q;
        if (bus.in_valid) begin
            hist_nxt = {hist_q[2:0], bus.in};
            if (fill_q != 3'd4) begin
                fill_nxt = fill_q + 3'd1;
            end
        end
        hit    = bus.in_valid && (fill_nxt == 3'd4) && (hist_nxt == pat_q);
        cnt_nxt = cnt_q + CNT_W'(1);
        win_nxt = win_q + WIN_W'(1);
        last   = hit && (cnt_nxt == tgt_q);
        expire = (win_len_q != '0) && (win_nxt == win_len_q);
    end

    // Control FSM with registered outputs; abort beats completion, completion beats expiry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            pat_q     <= '0;
            ovl_q     <= 1'b0;
            tgt_q     <= '0;
            win_len_q <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            win_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            match_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            match_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    busy_q <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        pat_q     <= bus.cfg_pattern;
                        ovl_q     <= bus.cfg_overlap;
                        // A zero target would never be reached; run to the first match.
                        tgt_q     <= (bus.cfg_target == '0) ? CNT_W'(1) : bus.cfg_target;
                        win_len_q <= bus.cfg_window;
                        cnt_q     <= '0;
                        fill_q    <= '0;
                        win_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= StArmed;
                    end
                end
                StArmed: begin
                    if (bus.abort) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        hist_q <= hist_nxt;
                        // Non-overlap mode demands four fresh bits after each match.
                        fill_q <= (hit && !ovl_q) ? 3'd0 : fill_nxt;
                        win_q  <= win_nxt;
                        if (hit) begin
                            match_q <= 1'b1;
                            cnt_q   <= cnt_nxt;
                        end
                        if (last) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else if (expire) begin
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                            state_q   <= StTimeout;
                        end
                    end
                end
                StDone, StTimeout: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.match     = match_q;
    assign bus.match_cnt = cnt_q;
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_pulse_det_ctrl.sv
// Directed bench for pulse_det_ctrl: each step pushes the hand-derived expected
// outputs to a scoreboard, clocks once, then pops and checks them.
module tb_pulse_det_ctrl;

    typedef struct {
        logic       busy;
        logic       match;
        logic       done;
        logic       timeout;
        logic [7:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;

    pulse_det_ctrl_if #(.CNT_W(8), .WIN_W(16)) bus ();

    pulse_det_ctrl #(.CNT_W(8), .WIN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [3:0] p, input logic o, input logic [7:0] tg,
                       input logic [15:0] w);
        bus.cfg_pattern = p;
        bus.cfg_overlap = o;
        bus.cfg_target  = tg;
        bus.cfg_window  = w;
    endtask

    // Drive one cycle of inputs, expect outputs (busy, match, done, timeout, cnt) after the edge.
    task automatic step(input logic s, input logic a, input logic v, input logic b,
                        input logic eb, input logic em, input logic ed, input logic et,
                        input logic [7:0] ec);
        exp_t e;
        exp_t g;
        e.busy = eb; e.match = em; e.done = ed; e.timeout = et; e.cnt = ec;
        sb.push_back(e);
        bus.start    = s;
        bus.abort    = a;
        bus.in_valid = v;
        bus.in       = b;
        @(posedge clk);
        #1;
        step_no++;
        g = sb.pop_front();
        check($sformatf("s%0d busy", step_no), 32'(bus.busy), 32'(g.busy));
        check($sformatf("s%0d match", step_no), 32'(bus.match), 32'(g.match));
        check($sformatf("s%0d done", step_no), 32'(bus.done), 32'(g.done));
        check($sformatf("s%0d timeout", step_no), 32'(bus.timeout), 32'(g.timeout));
        check($sformatf("s%0d match_cnt", step_no), 32'(bus.match_cnt), 32'(g.cnt));
    endtask

    initial begin
        rst = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.in = 1'b0; bus.in_valid = 1'b0;
        cfg(4'b1001, 1'b1, 8'd2, 16'd0);
        #12;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset match", 32'(bus.match), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset timeout", 32'(bus.timeout), 32'd0);
        check("reset match_cnt", 32'(bus.match_cnt), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Overlap, target 2: matches after bits 4 and 7, then done.
        cfg(4'b1001, 1'b1, 8'd2, 16'd0);
        step(1, 0, 0, 0,  1, 0, 0, 0, 0);
        step(0, 0, 1, 1,  1, 0, 0, 0, 0);
        step(0, 0, 1, 0,  1, 0, 0, 0, 0);
        step(0, 0, 1, 0,  1, 0, 0, 0, 0);
        step(0, 0, 1, 1,  1, 1, 0, 0, 1);
        step(0, 0, 1, 0,  1, 0, 0, 0, 1);
        step(0, 0, 1, 0,  1, 0, 0, 0, 1);
        step(0, 0, 1, 1,  0, 1, 1, 0, 2);
        step(1, 0, 0, 0,  0, 0, 0, 0, 2);   // start in DONE is ignored
        step(0, 0, 0, 0,  0, 0, 0, 0, 2);

        // Non-overlap: one match only, run stays armed; then abort.
        cfg(4'b1001, 1'b0, 8'd2, 16'd0);
        step(1, 0, 0, 0,  1, 0, 0, 0, 0);
        step(0, 0, 1, 1,  1, 0, 0, 0, 0);
        step(0, 0, 1, 0,  1, 0, 0, 0, 0);
        step(0, 0, 1, 0,  1, 0, 0, 0, 0);
        step(0, 0, 1, 1,  1, 1, 0, 0, 1);
        step(0, 0, 1, 0,  1, 0, 0, 0, 1);
        step(0, 0, 1, 0,  1, 0, 0, 0, 1);
        step(0, 0, 1, 1,  1, 0, 0, 0, 1);
        cfg(4'b0000, 1'b1, 8'd1, 16'd3);    // ignored while armed
        step(1, 0, 1, 0,  1, 0, 0, 0, 1);
        step(0, 0, 1, 0,  1, 0, 0, 0, 1);
        step(0, 0, 1, 0,  1, 0, 0, 0, 1);
        step(0, 1, 1, 1,  0, 0, 0, 0, 1);
        step(1, 1, 0, 0,  0, 0, 0, 0, 1);   // start+abort in IDLE stays idle
        step(0, 1, 0, 0,  0, 0, 0, 0, 1);

        // Window 10 with all zeros: timeout after 10 armed cycles.
        cfg(4'b1001, 1'b1, 8'd1, 16'd10);
        step(1, 0, 0, 0,  1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 1, 0,  1, 0, 0, 0, 0);
        end
        step(0, 0, 1, 0,  0, 0, 0, 1, 0);
        step(0, 0, 1, 0,  0, 0, 0, 0, 0);

        // Window 4, final match on the 4th armed edge: done wins.
        cfg(4'b1001, 1'b1, 8'd1, 16'd4);
        step(1, 0, 0, 0,  1, 0, 0, 0, 0);
        step(0, 0, 1, 1,  1, 0, 0, 0, 0);
        step(0, 0, 1, 0,  1, 0, 0, 0, 0);
        step(0, 0, 1, 0,  1, 0, 0, 0, 0);
        step(0, 0, 1, 1,  0, 1, 1, 0, 1);
        step(0, 0, 0, 0,  0, 0, 0, 0, 1);

        // Abort on the completing match edge.
        cfg(4'b1001, 1'b1, 8'd2, 16'd0);
        step(1, 0, 0, 0,  1, 0, 0, 0, 0);
        step(0, 0, 1, 1,  1, 0, 0, 0, 0);
        step(0, 0, 1, 0,  1, 0, 0, 0, 0);
        step(0, 0, 1, 0,  1, 0, 0, 0, 0);
        step(0, 0, 1, 1,  1, 1, 0, 0, 1);
        step(0, 0, 1, 0,  1, 0, 0, 0, 1);
        step(0, 0, 1, 0,  1, 0, 0, 0, 1);
        step(0, 1, 1, 1,  0, 0, 0, 0, 1);
        step(0, 0, 0, 0,  0, 0, 0, 0, 1);

        // Reset mid-run with match_cnt=1, then a target-0 (=1) run.
        cfg(4'b1001, 1'b1, 8'd2, 16'd0);
        step(1, 0, 0, 0,  1, 0, 0, 0, 0);
        step(0, 0, 1, 1,  1, 0, 0, 0, 0);
        step(0, 0, 1, 0,  1, 0, 0, 0, 0);
        step(0, 0, 1, 0,  1, 0, 0, 0, 0);
        step(0, 0, 1, 1,  1, 1, 0, 0, 1);
        rst = 1'b0;
        #1;
        check("async rst busy", 32'(bus.busy), 32'd0);
        check("async rst match", 32'(bus.match), 32'd0);
        check("async rst done", 32'(bus.done), 32'd0);
        check("async rst timeout", 32'(bus.timeout), 32'd0);
        check("async rst match_cnt", 32'(bus.match_cnt), 32'd0);
        #1;
        rst = 1'b1;
        step(0, 0, 1, 1,  0, 0, 0, 0, 0);
        cfg(4'b1001, 1'b1, 8'd0, 16'd0);
        step(1, 0, 0, 0,  1, 0, 0, 0, 0);
        step(0, 0, 1, 1,  1, 0, 0, 0, 0);
        step(0, 0, 1, 0,  1, 0, 0, 0, 0);
        step(0, 0, 1, 0,  1, 0, 0, 0, 0);
        step(0, 0, 1, 1,  0, 1, 1, 0, 1);
        step(0, 0, 0, 0,  0, 0, 0, 0, 1);

        check("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_det_ctrl.md
PULSE_DET_CTRL -- requirements
Module: pulse_det_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning width of the match target and count.
REQ-002 SHALL have parameter WIN_W, default 16, meaning width of the armed-window length.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-005 SHALL have port start  input  1  request to arm; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel an armed run.
REQ-007 SHALL have port cfg_pattern  input  4  target pattern; bit 3 is the first serial bit.
REQ-008 SHALL have port cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL have port cfg_target  input  CNT_W  matches required to finish; 0 is treated as 1.
REQ-010 SHALL have port cfg_window  input  WIN_W  maximum armed cycles; 0 = no timeout.
REQ-011 SHALL have port in  input  1  serial data bit.
REQ-012 SHALL have port in_valid  input  1  qualifies in; bits with in_valid=0 are ignored.
REQ-013 SHALL have port busy  output  1  high while in ARMED.
REQ-014 SHALL have port match  output  1  registered one-cycle pulse per detected pattern.
REQ-015 SHALL have port match_cnt  output  CNT_W  matches counted in the current or last run.
REQ-016 SHALL have port done  output  1  one-cycle pulse when match_cnt reaches the target.
REQ-017 SHALL have port timeout  output  1  one-cycle pulse when the window expires first.

Function
REQ-018 SHALL implement a one-hot FSM with states IDLE, ARMED, DONE, TIMEOUT.
REQ-019 IDLE: start=1 and abort=0 SHALL latch all cfg_* inputs, clear match_cnt, the history fill count and the window counter, and go to ARMED; busy=1 in the next cycle.
REQ-020 start SHALL be ignored in ARMED, DONE and TIMEOUT; cfg_* changes while armed SHALL have no effect.
REQ-021 ARMED: each edge with in_valid=1 SHALL shift in into a 4-bit history and increment a fill count saturating at 4.
REQ-022 A match SHALL occur when the updated history equals the latched pattern and the fill count is 4; match=1 in the cycle after that edge (latency 1).
REQ-023 Overlap mode SHALL keep the history after a match; non-overlap mode SHALL reset the fill count to 0 so that 4 fresh bits are needed.
REQ-024 Each match SHALL increment match_cnt in the same cycle match is asserted; when the new value equals the effective target, the FSM SHALL enter DONE.
REQ-025 The window counter SHALL increment on every ARMED cycle; when cfg_window is nonzero and cfg_window armed cycles have elapsed, the FSM SHALL enter TIMEOUT.
REQ-026 If the final match and window expiry fall on the same edge, DONE SHALL win and timeout SHALL stay 0.
REQ-027 abort=1 in ARMED SHALL return to IDLE on the next edge with no done or timeout pulse, overriding a same-edge match, completion or expiry; match_cnt SHALL hold.
REQ-028 abort SHALL be ignored outside ARMED; start and abort together in IDLE SHALL leave the block in IDLE.
REQ-029 DONE and TIMEOUT SHALL each last exactly one cycle, with done=1 and timeout=1 respectively, and then go to IDLE.
REQ-030 match_cnt SHALL hold its value in IDLE until the next accepted start; it never exceeds the target.
REQ-031 An illegal state encoding SHALL recover to IDLE on the next edge.

Reset
REQ-032 When rst=0, the block SHALL immediately enter IDLE and clear busy, match, done, timeout, match_cnt, the history, the fill count and the window counter.
REQ-033 Reset asserted mid-ARMED SHALL discard the run with no done or timeout pulse; the first start after rst returns to 1 SHALL operate normally.

Verification
REQ-034 pattern=1001, overlap=1, target=2, window=0, stream 1,0,0,1,0,0,1 (valid every cycle) -> match pulses after bits 4 and 7, match_cnt=2, one done pulse, then IDLE.
REQ-035 Same stream with overlap=0 -> exactly one match, match_cnt=1, no done, busy stays 1.
REQ-036 window=10, target=1, stream of all zeros -> timeout pulse after exactly 10 armed cycles, match_cnt=0, then IDLE.
REQ-037 window=4, pattern 1001 completed on the 4th armed edge, target=1 -> done=1, timeout=0.
REQ-038 abort on the same edge as a completing match -> no match, done or timeout pulse; IDLE; match_cnt unchanged.
REQ-039 rst=0 mid-ARMED with match_cnt=1 -> all outputs 0 immediately; a new run with target=1 completes normally.
